fetch_queue: RTL and testbench

- Instruction fetch buffer that consumes the PC stream and delivers it to decode. It sits between the PC register plus combinational instruction memory and the ID stage.
- Each cycle it captures the {PC, instruction} pair presented by fetch into a small FIFO. It hands entries to decode over a valid/ready handshake.
- It asserts pause back to the PC register when it cannot accept, and drops all buffered entries on a redirect (taken branch/jump).

---
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the PC register / instruction
// memory and the decode stage. Captures {PC, instruction} pairs into a small
// circular FIFO, presents the head entry to decode over valid/ready, holds
// the PC with pause when full, and discards everything on a redirect.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   fetch presents a valid {in_pc, in_instr} pair
//   in_pc      PC of the fetched instruction
//   in_instr   instruction word read at in_pc
//   flush      redirect from EX; drop all buffered entries and the current pair
//   out_ready  decode accepts the head entry
//   out_valid  head entry is valid
//   out_pc     PC of head entry (0 when empty)
//   out_instr  instruction of head entry (0 when empty)
//   pause      hold the PC register (queue full)
//   count      number of valid entries, 0..DEPTH
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic          pause,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   head;
  logic          push;
  logic          pop;

  // Pause and the full test depend only on registered count, so out_ready
  // never reaches pause combinationally; a pop in a full cycle does not
  // make room for a push in that same cycle.
  assign push = in_valid && (count_q != FULL_CNT) && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? head[63:32] : '0;
  assign out_instr = out_valid ? head[31:0]  : '0;
  assign pause     = (count_q == FULL_CNT);
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   in_pc = '0;
  logic [31:0]   in_instr = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          pause;
  logic [AW:0]   count;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .pause(pause), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of {pc, instr} pairs.
  logic [63:0] mq[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() != DEPTH);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({in_pc, in_instr});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] hd;
      hd = (mq.size() != 0) ? mq[0] : 64'h0;
      check("m_count", 64'(count), 64'(mq.size()));
      check("m_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("m_pause", 64'(pause), 64'(mq.size() == DEPTH));
      check("m_pc", 64'(out_pc), 64'(hd[63:32]));
      check("m_instr", 64'(out_instr), 64'(hd[31:0]));
      if (count > (AW+1)'(DEPTH)) begin
        errs++;
        $display("FAIL count_range: got %0d expected <= %0d", count, DEPTH);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = pc ^ 32'hA5A5A5A5;
  endtask

  initial begin
    logic [31:0] got[$];
    int nxt;
    int cyc;

    // Reset with fetch already presenting a pair.
    #1 rstn = 1'b0;
    drive(1'b1, 32'h40);
    out_ready = 1'b0;
    chk_en = 1'b1;
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_pause", 64'(pause), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("rel_count", 64'(count), 64'd1);
    check("rel_pc", 64'(out_pc), 64'h40);

    // Empty it via flush.
    flush = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    flush = 1'b0;
    check("flush0_count", 64'(count), 64'd0);

    // Streaming: one push and one pop per cycle, occupancy stays at one.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4));
      tick();
      check("str_count", 64'(count), 64'd1);
      check("str_pc", 64'(out_pc), 64'(i * 4));
      check("str_instr", 64'(out_instr), 64'((i * 4) ^ 32'hA5A5A5A5));
    end
    drive(1'b0, 32'h0);
    tick();
    check("str_drain", 64'(out_valid), 64'd0);

    // Fill to full; held pair must not be stored.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h80 + 32'(i * 4));
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_pause", 64'(pause), 64'd1);
    drive(1'b1, 32'h90);
    tick();
    check("held_count", 64'(count), 64'd4);
    check("held_pc", 64'(out_pc), 64'h80);
    out_ready = 1'b1;
    tick();
    check("popfull_count", 64'(count), 64'd3);
    check("popfull_pause", 64'(pause), 64'd0);
    check("popfull_pc", 64'(out_pc), 64'h84);
    out_ready = 1'b0;
    tick();
    check("refill_count", 64'(count), 64'd4);
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fill_order", 64'(out_pc), 64'(32'h84 + 32'(i * 4)));
      tick();
    end
    check("fill_empty", 64'(count), 64'd0);

    // Wrap-around: irregular bursts, 16 entries through a 4-deep ring.
    nxt = 0;
    cyc = 0;
    while (got.size() < 16 && cyc < 300) begin
      logic v;
      v = (nxt < 16) && ((cyc % 5) != 4);
      out_ready = ((cyc % 7) >= 3);
      drive(v, 32'h300 + 32'(nxt * 4));
      if (out_valid && out_ready) got.push_back(out_pc);
      if (v && mq.size() != DEPTH) nxt++;
      tick();
      cyc++;
    end
    if (got.size() != 16) begin
      errs++;
      $display("FAIL wrap_timeout: got %0d entries expected 16", got.size());
    end
    for (int i = 0; i < got.size(); i++)
      check("wrap_seq", 64'(got[i]), 64'(32'h300 + 32'(i * 4)));
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Flush with a push and pop pending in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4));
      tick();
    end
    check("pref_count", 64'(count), 64'd3);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h10C);
    tick();
    flush = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h200);
    tick();
    check("postfl_pc", 64'(out_pc), 64'h200);
    check("postfl_count", 64'(count), 64'd1);

    // Async reset between edges with two entries queued.
    drive(1'b1, 32'h204);
    tick();
    check("pre_ar_count", 64'(count), 64'd2);
    drive(1'b0, 32'h0);
    #2 rstn = 1'b0;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_pause", 64'(pause), 64'd0);
    check("ar_pc", 64'(out_pc), 64'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4));
      tick();
    end
    check("ar_full", 64'(count), 64'd4);
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ar_order", 64'(out_pc), 64'(32'h400 + 32'(i * 4)));
      tick();
    end
    check("ar_empty", 64'(out_valid), 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
